// File: rtl/uart_tx_slave.sv
// rtl/uart_tx_slave.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the data-side bus
module uart_tx_slave #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        conf_en,
  input  logic [3:0]  conf_wen,
  input  logic [31:0] conf_addr,
  input  logic [31:0] conf_wdata,
  output logic [31:0] conf_rdata,
  output logic        uart_txd,
  output logic        tx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_next;
  logic [15:0]     bitcnt, bitcnt_next;
  logic [2:0]      idx, idx_next;
  logic [7:0]      shift, shift_next;
  logic            txd_next;
  logic            pop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, count_next;
  logic            full, empty;
  logic            push_req, push_ok;

  logic [15:0]     div;
  logic            ie, ie_next;
  logic            ovf;
  logic [1:0]      reg_sel;
  logic            wr_fire, rd_fire;
  logic [31:0]     status;

  logic            unused_bits;
  assign unused_bits = ^{conf_addr[31:4], conf_addr[1:0], conf_wdata[31:16], conf_wen[3:2]};

  assign reg_sel  = conf_addr[3:2];
  assign wr_fire  = conf_en && (|conf_wen);
  assign rd_fire  = conf_en && (conf_wen == 4'b0000);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr_fire && (reg_sel == 2'd0) && conf_wen[0];
  // a push against a full FIFO still lands if the FSM frees a slot on the same edge
  assign push_ok  = push_req && (!full || pop);
  assign status   = {20'b0, 4'(count), 3'b0, ie, ovf, (state != S_IDLE), empty, full};

  // next FIFO occupancy and interrupt enable, shared by the registers and the irq flop
  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    ie_next = ie;
    if (wr_fire && (reg_sel == 2'd1) && conf_wen[0]) ie_next = conf_wdata[4];
  end

  // TX sequencing: every bit lasts div+1 cycles, reloading from the live divisor at each boundary
  always_comb begin
    state_next  = state;
    bitcnt_next = bitcnt;
    idx_next    = idx;
    shift_next  = shift;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          shift_next  = mem[rptr];
          bitcnt_next = div;
          state_next  = S_START;
        end
      end
      S_START: begin
        if (bitcnt == 16'd0) begin
          bitcnt_next = div;
          idx_next    = 3'd0;
          state_next  = S_DATA;
        end else begin
          bitcnt_next = bitcnt - 16'd1;
        end
      end
      S_DATA: begin
        if (bitcnt == 16'd0) begin
          bitcnt_next = div;
          if (idx == 3'd7) begin
            state_next = S_STOP;
          end else begin
            shift_next = {1'b0, shift[7:1]};
            idx_next   = idx + 3'd1;
          end
        end else begin
          bitcnt_next = bitcnt - 16'd1;
        end
      end
      S_STOP: begin
        if (bitcnt == 16'd0) begin
          if (!empty) begin
            pop         = 1'b1;
            shift_next  = mem[rptr];
            bitcnt_next = div;
            state_next  = S_START;
          end else begin
            state_next  = S_IDLE;
          end
        end else begin
          bitcnt_next = bitcnt - 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    case (state_next)
      S_START: txd_next = 1'b0;
      S_DATA:  txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  // FSM state, shifter, serial line and interrupt flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      bitcnt   <= '0;
      idx      <= '0;
      shift    <= '0;
      uart_txd <= 1'b1;
      tx_irq   <= 1'b0;
    end else begin
      state    <= state_next;
      bitcnt   <= bitcnt_next;
      idx      <= idx_next;
      shift    <= shift_next;
      uart_txd <= txd_next;
      tx_irq   <= (state_next == S_IDLE) && (count_next == '0) && ie_next;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= conf_wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      count <= count_next;
    end
  end

  // control registers: divisor bytes, interrupt enable, sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= DEFAULT_DIV;
      ie  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      ie <= ie_next;
      if (push_req && full && !pop) begin
        ovf <= 1'b1;
      end else if (wr_fire && (reg_sel == 2'd1) && conf_wen[0] && conf_wdata[3]) begin
        ovf <= 1'b0;
      end
      if (wr_fire && (reg_sel == 2'd2)) begin
        if (conf_wen[0]) div[7:0]  <= conf_wdata[7:0];
        if (conf_wen[1]) div[15:8] <= conf_wdata[15:8];
      end
    end
  end

  // registered read data reflecting state before the sampling edge; holds when not read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_rdata <= '0;
    end else if (rd_fire) begin
      case (reg_sel)
        2'd1:    conf_rdata <= status;
        2'd2:    conf_rdata <= {16'b0, div};
        default: conf_rdata <= 32'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_slave.sv
// tb/tb_uart_tx_slave.sv - directed self-checking bench for uart_tx_slave
module tb_uart_tx_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;
  logic        uart_txd;
  logic        tx_irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_slave #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
    .clk        (clk),
    .reset      (reset),
    .conf_en    (conf_en),
    .conf_wen   (conf_wen),
    .conf_addr  (conf_addr),
    .conf_wdata (conf_wdata),
    .conf_rdata (conf_rdata),
    .uart_txd   (uart_txd),
    .tx_irq     (tx_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    @(negedge clk);
    conf_en = 1'b1; conf_wen = wen; conf_addr = addr; conf_wdata = data;
    @(negedge clk);
    conf_en = 1'b0; conf_wen = 4'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    conf_en = 1'b1; conf_wen = 4'b0; conf_addr = addr;
    @(negedge clk);
    conf_en = 1'b0;
    data = conf_rdata;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    else if (p <= 8) return b[p-1];
    else return 1'b1;
  endfunction

  logic [31:0] d;
  logic [63:0] wave, exp_w, aux, exp_a;
  logic        ok;

  initial begin
    reset = 1'b0; conf_en = 1'b0; conf_wen = 4'b0; conf_addr = '0; conf_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // reset state
    check("rst_txd", 64'(uart_txd), 64'd1);
    check("rst_irq", 64'(tx_irq), 64'd0);
    check("rst_rdata", 64'(conf_rdata), 64'd0);
    bus_read(32'h4, d); check("rst_status", 64'(d), 64'h2);
    bus_read(32'h8, d); check("rst_div", 64'(d), 64'd433);

    // byte enables and reserved address
    bus_write(32'h0, 4'b0010, 32'hAB);
    bus_read(32'h4, d); check("be_txdata_ignored", 64'(d), 64'h2);
    bus_write(32'h8, 4'b0001, 32'h1234);
    bus_read(32'h8, d); check("be_div_low_only", 64'(d), 64'h134);
    bus_write(32'hC, 4'hF, 32'hFFFF_FFFF);
    bus_read(32'hC, d); check("reserved_read", 64'(d), 64'h0);
    bus_read(32'h8, d); check("reserved_write_ignored", 64'(d), 64'h134);

    // single frame 0x55 at div 3, busy polled every cycle
    bus_write(32'h8, 4'b0011, 32'd3);
    bus_write(32'h0, 4'b0001, 32'h55);
    conf_en = 1'b1; conf_wen = 4'b0; conf_addr = 32'h4;
    wave = '0; exp_w = '0; aux = '0; exp_a = '0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      wave[i]  = uart_txd;
      aux[i]   = conf_rdata[2];
      exp_w[i] = (i < 40) ? frame_bit(8'h55, i / 4) : 1'b1;
      exp_a[i] = (i > 0);
    end
    conf_en = 1'b0;
    check("frame55_txd", wave, exp_w);
    check("frame55_busy", aux, exp_a);
    bus_read(32'h4, d); check("frame55_idle_status", 64'(d), 64'h2);
    check("frame55_no_irq_ie0", 64'(tx_irq), 64'd0);

    // overflow: 10 back-to-back pushes at a very slow divisor
    bus_write(32'h8, 4'b0011, 32'hFFFF);
    @(negedge clk);
    conf_en = 1'b1; conf_wen = 4'b0001; conf_addr = 32'h0;
    for (int k = 0; k < 10; k++) begin
      conf_wdata = 32'h10 + k;
      @(negedge clk);
    end
    conf_en = 1'b0; conf_wen = 4'b0;
    bus_read(32'h4, d); check("ovf_status", 64'(d), 64'h80D);
    bus_write(32'h4, 4'b0001, 32'h08);
    bus_read(32'h4, d); check("ovf_w1c", 64'(d), 64'h805);
    check("ovf_txd_in_start", 64'(uart_txd), 64'd0);
    #2 reset = 1'b0;
    #1 check("async_reset_txd", 64'(uart_txd), 64'd1);
    @(negedge clk); reset = 1'b1;
    bus_read(32'h4, d); check("post_reset_status", 64'(d), 64'h2);

    // back-to-back frames 0x00, 0xFF at div 1 with IE set
    bus_write(32'h8, 4'b0011, 32'd1);
    bus_write(32'h4, 4'b0001, 32'h10);
    check("irq_idle_ie", 64'(tx_irq), 64'd1);
    @(negedge clk);
    conf_en = 1'b1; conf_wen = 4'b0001; conf_addr = 32'h0; conf_wdata = 32'h00;
    @(negedge clk);
    conf_wdata = 32'hFF;
    @(negedge clk);
    conf_en = 1'b0; conf_wen = 4'b0;
    wave = '0; exp_w = '0; aux = '0; exp_a = '0;
    for (int i = 0; i < 42; i++) begin
      wave[i]  = uart_txd;
      aux[i]   = tx_irq;
      if (i >= 40)        exp_w[i] = 1'b1;
      else if (i / 2 < 10) exp_w[i] = frame_bit(8'h00, i / 2);
      else                exp_w[i] = frame_bit(8'hFF, i / 2 - 10);
      exp_a[i] = (i >= 40);
      @(negedge clk);
    end
    check("b2b_txd", wave, exp_w);
    check("b2b_irq", aux, exp_a);

    // reset in the middle of DATA bit 3 of 0xA5 at div 3
    bus_write(32'h8, 4'b0011, 32'd3);
    bus_write(32'h0, 4'b0001, 32'hA5);
    repeat (16) @(negedge clk);
    check("mid_txd_bit2", 64'(uart_txd), 64'd1);
    repeat (2) @(negedge clk);
    check("mid_txd_bit3", 64'(uart_txd), 64'd0);
    #2 reset = 1'b0;
    #1 check("mid_async_txd", 64'(uart_txd), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) ok = 1'b0;
    end
    check("mid_no_frame_after", 64'(ok), 64'd1);
    bus_read(32'h4, d); check("mid_status", 64'(d), 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_slave.md
# uart_tx_slave

Memory-mapped UART transmitter that sits as a responder on the CPU data-side sram-like bus, next to `confreg` behind the 1×N data bridge. The CPU writes bytes into an 8-entry FIFO, and a TX state machine serialises them onto `uart_txd` as 8N1 frames at a programmable divisor. Read data returns with the same one-cycle registered latency as the data sram, so the bridge treats this block exactly like any other slave.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of 2, ≥2.
- `DEFAULT_DIV`, 16'd433: reset value of DIVISOR. Bit period = DIVISOR+1 clocks (434 clocks = 115200 baud at 50 MHz).

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `conf_en` in 1: access strobe; this device was selected by the bridge.
- `conf_wen` in 4: byte write enables; 0 means read.
- `conf_addr` in 32: byte address; only `[3:2]` is decoded.
- `conf_wdata` in 32: write data.
- `conf_rdata` out 32: registered read data.
- `uart_txd` out 1: serial output; idle high.
- `tx_irq` out 1: level; high when the FIFO is empty, the FSM is IDLE and IE=1.

## Operation
- Register map, indexed by `conf_addr[3:2]`:
  - 0 TXDATA (W): a write with `conf_wen[0]=1` pushes `wdata[7:0]`. Reads return 0.
  - 1 STATUS (R/W):
    - bit0 full; bit1 empty; bit2 busy (FSM ≠ IDLE); bit3 overflow (sticky); bit4 IE.
    - bits[11:8] FIFO count (0..FIFO_DEPTH); all other bits 0.
    - A write with `wen[0]=1` sets IE from `wdata[4]`. If `wdata[3]=1`, it also clears overflow (write-1-to-clear).
  - 2 DIVISOR (R/W): bits[15:0]. `wen[0]` writes `[7:0]` and `wen[1]` writes `[15:8]`. Reads return `{16'b0, div}`.
  - 3 reserved: reads return 0; writes are ignored.
- Write fires when `conf_en=1` and `|conf_wen`. Read fires when `conf_en=1` and `conf_wen=0`. When `conf_en=0`, the block takes no action and `conf_rdata` holds.
- FIFO behaviour:
  - Push to TXDATA while full is dropped and sets overflow, unless a pop occurs in the same cycle; in that case it is accepted and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is `$clog2(FIFO_DEPTH)+1` bits wide.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty: pop into an 8-bit shift register and load bitcnt=div.
  - Each state lasts div+1 cycles. bitcnt decrements to 0, then reloads from the *current* DIVISOR at every bit boundary, so a divisor write takes effect from the next bit.
  - START drives 0, then moves to DATA with index 0.
  - DATA drives `shift[0]`, LSB first, and shifts right each bit. After 8 bits it moves to STOP.
  - STOP drives 1. At its end:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- `uart_txd` is registered. Its value is a pure function of FSM state and shift bit.

## Timing
- Reset values:
  - `uart_txd`=1, `conf_rdata`=0, `tx_irq`=0.
  - FIFO empty; FSM IDLE; DIVISOR=DEFAULT_DIV; overflow=0; IE=0.
- Read latency: 1 cycle. `conf_rdata` is valid after the edge that samples the read. It reflects state *before* that edge, so a same-cycle push is not visible.
- Write→TX latency: a write at edge N makes the FIFO non-empty. At edge N+1 the FSM pops and `uart_txd` goes low.
- Frame length: exactly 10×(div+1) cycles.
- Reset asserted mid-frame: `uart_txd` goes to 1 immediately (asynchronously). FIFO contents and the partial frame are discarded.
- `tx_irq` is registered and asserts the cycle after the STOP bit completes with the FIFO empty.

## Test plan
- Reset check: release reset, then read STATUS. Expect `conf_rdata`=0x0000_0002 one cycle later, `uart_txd`=1, and DIVISOR read = 433.
- Single frame: write DIVISOR=3, then TXDATA=0x55.
  - `uart_txd` is low 4 cycles starting the edge after the write.
  - Data bits follow as 1,0,1,0,1,0,1,0, each 4 cycles, then stop high 4 cycles; total 40 cycles.
  - busy reads 1 throughout.
- Overflow: set DIVISOR=0xFFFF and write 10 bytes back-to-back. The first is popped, 8 are queued and the 10th is dropped.
  - STATUS reads count=8, full=1, overflow=1.
  - Write STATUS with `wdata[3]=1`; overflow reads 0.
- Back-to-back frames: with DIVISOR=1, write 0x00 then 0xFF. The second start bit immediately follows the first stop bit, for 40 cycles total.
  - With IE=1, `tx_irq` rises 1 cycle after the final stop bit.
- Byte enables and reserved address:
  - Write TXDATA with wen=4'b0010: ignored, FIFO stays empty.
  - Write DIVISOR=0x1234 with wen=4'b0001: DIVISOR=0x0134 (from default 0x01B1).
  - Read addr 0xC: returns 0.
- Reset mid-frame: assert reset during DATA bit 3. `uart_txd` becomes 1 at once. After release, STATUS shows empty=1 and busy=0, and no further frame is emitted.
